adc_spi_control: RTL
====================

Name: adc_spi_control

Overview:
- Timing master for the serial ADC link. Generates the free-running serial clock SCLK and the active-low chip select CS from the system clock.
- Each conversion frame is exactly 16 SCLK falling edges with CS low. The ADC shifts data out on these edges; the downstream receiver samples on them.
- Sits directly upstream of the ADC receiver and drives both the ADC pins and the receiver's SCLK/CS inputs.
- Guarantees at least one SCLK falling edge with CS high between frames, so the receiver's load state can complete and emit its done tick.

Parameters:
- CLK_DIV, 5, clk cycles per SCLK half-period (minimum 1). SCLK frequency = f_clk / (2*CLK_DIV).
- N_BITS, 16, SCLK falling edges per frame with CS low.
- QUIET_EDGES, 2, minimum SCLK falling edges with CS high between frames (minimum 1).
- SAMPLE_PERIOD, 2500, clk cycles between automatic requests. Used only with ADC_CTRL_AUTO_EN.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  conversion request; a one-clk pulse or a level.
- SCLK  out  1  serial clock to ADC and receiver; idles high after reset.
- CS  out  1  active-low chip select.
- busy  out  1  high from frame start through the end of the quiet gap.
- frame_done  out  1  one-clk pulse when CS returns high.
- sample_tick  out  1  one-clk pulse per automatic request; tied 0 without ADC_CTRL_AUTO_EN.

Behaviour:
- Reset (async, active-high):
  - SCLK=1, CS=1, busy=0, frame_done=0, sample_tick=0.
  - State=IDLE; divider, bit counter, quiet counter and pending flag all cleared.
  - Asserting reset mid-frame forces CS high and SCLK high immediately, without waiting for a clk edge. No frame_done pulse is produced.
- Divider:
  - div_cnt runs 0..CLK_DIV-1.
  - At terminal count, SCLK toggles and div_cnt returns to 0.
  - rise_ev = terminal count while SCLK=0. fall_ev = terminal count while SCLK=1.
  - SCLK runs continuously in every state.
- Request latch:
  - start=1 in any cycle sets pending.
  - Multiple requests while pending or busy coalesce into one; at most one request is queued.
- CS changes only on rise_ev, so CS is stable at every falling edge.
- FSM:
  - IDLE: on rise_ev with pending=1, drive CS=0, clear pending, bit_cnt=0, busy=1, go to SHIFT.
  - SHIFT: increment bit_cnt on each fall_ev. On the first rise_ev after bit_cnt reaches N_BITS, drive CS=1, pulse frame_done for that clk, quiet_cnt=0, go to QUIET.
  - QUIET: increment quiet_cnt on each fall_ev. On the first rise_ev with quiet_cnt >= QUIET_EDGES:
    - if pending=1, start a new frame directly (same actions as IDLE); busy stays 1;
    - otherwise go to IDLE with busy=0.
  - Illegal state encodings return to IDLE with CS=1.
- Latency:
  - From start to CS falling: at most 2*CLK_DIV+1 clk cycles when in IDLE.
  - Frame length, CS falling to CS rising: exactly N_BITS SCLK periods.
- Width rules:
  - Counters use $clog2(param+1) bits.
  - bit_cnt saturates at N_BITS; no wrap.
- A start pulse in the same cycle that pending is cleared by a frame start sets pending again and yields one further frame.

Optional Feature:
- Macro: ADC_CTRL_AUTO_EN.
- Defined:
  - A free-running timer counts 0..SAMPLE_PERIOD-1 and pulses sample_tick at terminal count.
  - sample_tick ORs into the request latch.
  - External start remains functional.
  - Timer is cleared by reset.
- Undefined: no timer logic; sample_tick is driven constant 0; frames start only on start.

Test Plan:
- Reset: assert reset mid-SHIFT (CLK_DIV=5) -> CS=1 and SCLK=1 in the same cycle. All outputs at reset values and no frame_done pulse; after release, SCLK toggles every 5 clk.
- Single frame: one start pulse in IDLE -> CS low for exactly 16 SCLK periods (160 clk at CLK_DIV=5).
  - Both CS edges coincide with SCLK rising edges.
  - Exactly 16 falling edges with CS=0.
  - frame_done is a single 1-clk pulse at CS rise.
- Back-to-back: three start pulses during one frame -> exactly one additional frame.
  - Its CS fall occurs after exactly 2 falling edges with CS high.
  - busy stays 1 throughout, then drops.
- Chain with receiver and ADC model: model shifts 0x0ABC MSB-first on falling edges -> receiver data_Out=12'hABC and b_reg=16'h0ABC. rx_done_tick fires once per frame, during the quiet gap.
- Auto mode (ADC_CTRL_AUTO_EN, SAMPLE_PERIOD=2500): no start -> sample_tick every 2500 clk and one frame per tick. Without the macro, sample_tick stays 0 and no frames occur.

Source files
------------

// File: rtl/adc_spi_control.sv
// Serial ADC timing master: free-running SCLK, CS-framed 16-edge conversions with a quiet gap.
// Optional automatic request timer enabled by defining ADC_CTRL_AUTO_EN.
module adc_spi_control #(
    parameter int CLK_DIV       = 5,
    parameter int N_BITS        = 16,
    parameter int QUIET_EDGES   = 2,
    parameter int SAMPLE_PERIOD = 2500
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic SCLK,
    output logic CS,
    output logic busy,
    output logic frame_done,
    output logic sample_tick
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(N_BITS + 1);
    localparam int QW = $clog2(QUIET_EDGES + 1);
    localparam logic [DW-1:0] DIV_TC = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(N_BITS);
    localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_EDGES);

    typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [QW-1:0]   quiet_cnt;
    logic            pending;
    logic            req;
    logic            div_tc, rise_ev, fall_ev;

    assign div_tc  = (div_cnt == DIV_TC);
    assign rise_ev = div_tc & ~SCLK;
    assign fall_ev = div_tc & SCLK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            SCLK    <= 1'b1;
        end else if (div_tc) begin
            div_cnt <= '0;
            SCLK    <= ~SCLK;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

`ifdef ADC_CTRL_AUTO_EN
    localparam int TW = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [TW-1:0] TMR_TC = TW'(SAMPLE_PERIOD - 1);
    logic [TW-1:0] tmr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr         <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (tmr == TMR_TC);
            tmr         <= (tmr == TMR_TC) ? '0 : tmr + 1'b1;
        end
    end

    assign req = start | sample_tick;
`else
    assign sample_tick = 1'b0;
    assign req         = start;
`endif

    // CS only moves on rise_ev so the receiver sees it stable at every falling edge.
    // The request set comes after the FSM's clear so a same-cycle start queues one more frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            CS         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            bit_cnt    <= '0;
            quiet_cnt  <= '0;
            pending    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise_ev && pending) begin
                        state   <= SHIFT;
                        CS      <= 1'b0;
                        pending <= 1'b0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (fall_ev && bit_cnt != BIT_MAX)
                        bit_cnt <= bit_cnt + 1'b1;
                    if (rise_ev && bit_cnt == BIT_MAX) begin
                        state      <= QUIET;
                        CS         <= 1'b1;
                        frame_done <= 1'b1;
                        quiet_cnt  <= '0;
                    end
                end
                QUIET: begin
                    if (fall_ev && quiet_cnt != QUIET_MAX)
                        quiet_cnt <= quiet_cnt + 1'b1;
                    if (rise_ev && quiet_cnt >= QUIET_MAX) begin
                        if (pending) begin
                            state   <= SHIFT;
                            CS      <= 1'b0;
                            pending <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    CS    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
            if (req)
                pending <= 1'b1;
        end
    end
endmodule
